switch_post_cell_buf: RTL and testbench
=======================================

// Module: switch_post_cell_buf
// PURPOSE
//  Next-generation egress post-buffer for the switch core. Takes the cell stream leaving the
//  crossbar (DATA_W-bit words, first/last framed, multi-hot port select) and stores frames
//  per egress port in store-and-forward queues. Each port sees a valid/ready word stream of
//  committed frames only; partial or overflowed frames never reach the port.
//  Generalises the fixed 4-port post stage: port count, width and depth are parameters;
//  adds multicast, per-port frame commit/rewind, and a programmable backpressure threshold.
// PARAMETERS
//  N_PORT   4    number of egress ports (1..16)
//  DATA_W   128  cell word width, bits
//  DEPTH    64   words per port queue; power of 2, >= 4
//  BP_FREE  16   bp[i] asserts while free words of port i < BP_FREE (1..DEPTH)
// PORTS
//  clk            in   1              core clock; single clock domain
//  rstn           in   1              asynchronous, active-low reset
//  in_wr          in   1              input word strobe
//  in_sel         in   N_PORT         multi-hot destination ports of the word
//  in_din         in   DATA_W         input word
//  in_first       in   1              word is first of frame
//  in_last        in   1              word is last of frame
//  in_bp          out  N_PORT         per-port backpressure, registered
//  out_valid      out  N_PORT         port i has a head word
//  out_ready      in   N_PORT         port i accepts head word
//  out_data       out  N_PORT*DATA_W  head word, port i at [i*DATA_W +: DATA_W]
//  out_first      out  N_PORT         head word is first of frame
//  out_last       out  N_PORT         head word is last of frame
//  drop_cnt       out  N_PORT*16      frames dropped per port (SWITCH_POST_DROP_CNT_EN only)
// BEHAVIOUR
//  Reset: in_bp=0, out_valid=0, out_data/out_first/out_last=0, drop_cnt=0; all pointers 0.
//  Reset mid-operation discards all queued and partial frames immediately.
//  Per port three pointers, width log2(DEPTH)+1: wr_ptr, cmt_ptr (committed end), rd_ptr.
//  used = wr_ptr - rd_ptr (modulo, includes uncommitted words); free = DEPTH - used.
//  Write, port i, when in_wr & in_sel[i] at an edge:
//   - in_first: opens frame; wr_ptr rewinds to cmt_ptr first (an unterminated previous
//     frame is silently discarded, not counted as a drop), then the word is written.
//   - no frame open and !in_first: word ignored.
//   - free==0 (no read this edge): word not stored, frame marked bad; remaining words
//     of the frame ignored.
//   - in_last: good frame -> cmt_ptr <= wr_ptr_next; bad frame -> wr_ptr <= cmt_ptr,
//     drop_cnt[i]++ (saturating at 16'hFFFF). Frame closes. first&last = 1-word frame.
//   - free==0 with a read on the same edge: write is accepted (read frees the slot).
//  Multicast: each selected port decides independently; one port dropping does not affect
//  others.
//  Read: out_valid[i]=1 while a word below cmt_ptr is in the output register (FWFT).
//   Transfer on out_valid&out_ready; next committed word presented the following cycle,
//   giving 1 word/cycle sustained. out_data stable while valid & !ready.
//  Latency: in_last sampled at edge k -> out_valid high after edge k+1 (empty queue).
//  in_bp[i] <= (free_next < BP_FREE), updated every edge; upstream must stop writing
//  port i while in_bp[i]=1 (up to 1 word in flight is absorbed by the BP_FREE margin).
//  Pointer wrap at DEPTH is natural modulo arithmetic; full = used==DEPTH.
// CONFIGURATION
//  SWITCH_POST_DROP_CNT_EN defined: per-port 16-bit saturating drop counters drive
//  drop_cnt. Undefined: counters not built, drop_cnt tied to 0; drop behaviour unchanged.
// STRUCTURE
//  Shared header switch_post_defs.vh: cell word width default, frame-state encoding
//  (IDLE/GOOD/BAD), counter width 16.
//  Sub-module switch_post_cell_q: one port queue (simple dual-port RAM DEPTH x (DATA_W+2)
//  holding data+first+last, pointer/commit logic, FWFT output register, bp and drop
//  counter); top instantiates N_PORT via generate and gates in_wr with in_sel[i].
// TESTING
//  1 Single 4-word frame to port 0, ready=1 -> out_valid[0] at edge k+1 after last; words
//    out in order, out_first on word 0, out_last on word 3; ports 1..3 stay invalid.
//  2 Multicast in_sel=4'b1010, 3-word frame -> identical frame on ports 1 and 3 only.
//  3 DEPTH=64, ready=0, write 70-word frame to port 2 -> no output, drop_cnt[2]=1, queue
//    empty; next 4-word frame then delivered intact.
//  4 Frame with first but no last, then new first -> only second frame delivered, drop
//    count 0.
//  5 ready=0, fill port 1 to 49 used (BP_FREE=16) -> in_bp[1]=1 one edge later; drain 2
//    words -> in_bp[1]=0.
//  6 Reset asserted mid-frame with queued data -> out_valid=0, in_bp=0 asynchronously;
//    after release a new frame passes normally.

Source files
------------

// File: rtl/switch_post_cell_buf_pkg.sv
// Shared definitions for the switch egress post-buffer.
//   CELL_W_DEF  default cell word width
//   CNT_W       width of the per-port drop counters
//   frm_state_t write-side frame state: no frame open, frame being stored,
//               frame overflowed (rest of it is discarded)
package switch_post_cell_buf_pkg;

  localparam int CELL_W_DEF = 128;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_GOOD = 2'd1,
    FS_BAD  = 2'd2
  } frm_state_t;

endpackage

// File: rtl/switch_post_cell_buf_q.sv
// One egress port queue of the switch post-buffer: store-and-forward frame
// storage with commit/rewind, a first-word-fall-through output register,
// registered backpressure and an optional saturating drop counter.
//
// Build option: SWITCH_POST_DROP_CNT_EN builds the drop counter; without it
// drop_cnt is tied to zero (drop behaviour itself is unchanged).
//
// Ports
//   clk, rstn    clock, asynchronous active-low reset
//   wr           word strobe already qualified with this port's select bit
//   din          input word
//   first, last  frame delimiters of the input word
//   bp           registered backpressure (free words after this edge < BP_FREE)
//   out_valid    head word present (committed frames only)
//   out_ready    consumer accepts head word
//   out_data     head word
//   out_first    head word opens a frame
//   out_last     head word closes a frame
//   drop_cnt     frames dropped on overflow, saturating
module switch_post_cell_buf_q
  import switch_post_cell_buf_pkg::*;
#(
  parameter int DATA_W  = CELL_W_DEF,
  parameter int DEPTH   = 64,
  parameter int BP_FREE = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              first,
  input  logic              last,
  output logic              bp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);
  localparam logic [PW-1:0] BP_V    = PW'(BP_FREE);
  localparam logic [PW-1:0] ONE     = PW'(1);

  // Storage word is {first, last, data}.
  logic [DATA_W+1:0] mem [DEPTH];

  // rd_ptr addresses the word currently held in the output register, so the
  // head word still counts as used until the consumer takes it.
  logic [PW-1:0] wr_ptr, cmt_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nx, cmt_ptr_nx, rd_ptr_nx;
  logic [PW-1:0] base_ptr, free_nx;
  frm_state_t    st, st_nx;
  logic          pop, room, mem_we, drop_evt, load, head_avail;
  logic [DATA_W+1:0] rd_word;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              first_p1, last_p1;

  always_comb begin
    pop        = vld_p1 & out_ready;
    rd_ptr_nx  = pop ? rd_ptr + ONE : rd_ptr;
    // A new first word rewinds over any unterminated frame before it lands.
    base_ptr   = (wr && first) ? cmt_ptr : wr_ptr;
    // A read on the same edge frees the slot a full queue would otherwise lack.
    room       = ((base_ptr - rd_ptr) != DEPTH_V) || pop;
    wr_ptr_nx  = wr_ptr;
    cmt_ptr_nx = cmt_ptr;
    st_nx      = st;
    mem_we     = 1'b0;
    drop_evt   = 1'b0;
    if (wr) begin
      if (first || st == FS_GOOD) begin
        if (room) begin
          mem_we    = 1'b1;
          wr_ptr_nx = base_ptr + ONE;
          if (last) begin
            cmt_ptr_nx = base_ptr + ONE;
            st_nx      = FS_IDLE;
          end else begin
            st_nx = FS_GOOD;
          end
        end else if (last) begin
          wr_ptr_nx = cmt_ptr;
          drop_evt  = 1'b1;
          st_nx     = FS_IDLE;
        end else begin
          // Stored words of the bad frame stay counted until its last word.
          wr_ptr_nx = base_ptr;
          st_nx     = FS_BAD;
        end
      end else if (st == FS_BAD && last) begin
        wr_ptr_nx = cmt_ptr;
        drop_evt  = 1'b1;
        st_nx     = FS_IDLE;
      end
    end
    free_nx = DEPTH_V - (wr_ptr_nx - rd_ptr_nx);
  end

  // Output register refills when empty or when its word is taken; only words
  // committed before this edge are eligible, which gives the one-edge latency
  // from last-word write to out_valid.
  assign load       = !vld_p1 || pop;
  assign head_avail = (rd_ptr_nx != cmt_ptr);
  assign rd_word    = mem[rd_ptr_nx[AW-1:0]];

  always_ff @(posedge clk) begin
    if (mem_we) mem[base_ptr[AW-1:0]] <= {first, last, din};
  end

  // Stage p1: pointer state and output register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      cmt_ptr  <= '0;
      rd_ptr   <= '0;
      st       <= FS_IDLE;
      bp       <= 1'b0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nx;
      cmt_ptr <= cmt_ptr_nx;
      rd_ptr  <= rd_ptr_nx;
      st      <= st_nx;
      bp      <= (free_nx < BP_V);
      if (load) begin
        vld_p1 <= head_avail;
        if (head_avail) {first_p1, last_p1, data_p1} <= rd_word;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_first = first_p1;
  assign out_last  = last_p1;

`ifdef SWITCH_POST_DROP_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] drop_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) drop_q <= '0;
    else if (drop_evt) drop_q <= sat_inc(drop_q);
  end

  assign drop_cnt = drop_q;
`else
  logic unused_drop_evt;
  assign unused_drop_evt = drop_evt;
  assign drop_cnt        = '0;
`endif

endmodule

// File: rtl/switch_post_cell_buf.sv
// Egress post-buffer of the switch core: the crossbar cell stream is stored
// per egress port in store-and-forward queues; each port sees only committed
// frames as a valid/ready word stream. Multicast words are offered to every
// selected port, and each port accepts or drops independently.
//
// Build option: SWITCH_POST_DROP_CNT_EN enables the per-port drop counters.
//
// Ports
//   clk, rstn   clock, asynchronous active-low reset
//   in_wr       input word strobe
//   in_sel      multi-hot destination ports
//   in_din      input word
//   in_first    word opens a frame
//   in_last     word closes a frame
//   in_bp       per-port registered backpressure
//   out_valid   per-port head word present
//   out_ready   per-port head word accepted
//   out_data    head words, port i at [i*DATA_W +: DATA_W]
//   out_first   per-port head word opens a frame
//   out_last    per-port head word closes a frame
//   drop_cnt    per-port 16-bit drop counters, port i at [i*16 +: 16]
module switch_post_cell_buf
  import switch_post_cell_buf_pkg::*;
#(
  parameter int N_PORT  = 4,
  parameter int DATA_W  = CELL_W_DEF,
  parameter int DEPTH   = 64,
  parameter int BP_FREE = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_wr,
  input  logic [N_PORT-1:0]       in_sel,
  input  logic [DATA_W-1:0]       in_din,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic [N_PORT-1:0]       in_bp,
  output logic [N_PORT-1:0]       out_valid,
  input  logic [N_PORT-1:0]       out_ready,
  output logic [N_PORT*DATA_W-1:0] out_data,
  output logic [N_PORT-1:0]       out_first,
  output logic [N_PORT-1:0]       out_last,
  output logic [N_PORT*CNT_W-1:0] drop_cnt
);

  for (genvar i = 0; i < N_PORT; i++) begin : g_port
    switch_post_cell_buf_q #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .BP_FREE (BP_FREE)
    ) u_q (
      .clk       (clk),
      .rstn      (rstn),
      .wr        (in_wr & in_sel[i]),
      .din       (in_din),
      .first     (in_first),
      .last      (in_last),
      .bp        (in_bp[i]),
      .out_valid (out_valid[i]),
      .out_ready (out_ready[i]),
      .out_data  (out_data[i*DATA_W +: DATA_W]),
      .out_first (out_first[i]),
      .out_last  (out_last[i]),
      .drop_cnt  (drop_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_switch_post_cell_buf.sv
module tb_switch_post_cell_buf;

  localparam int NP    = 4;
  localparam int DW    = 128;
  localparam int DEPTH = 64;
  localparam int BPF   = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_wr;
  logic [NP-1:0]    in_sel;
  logic [DW-1:0]    in_din;
  logic             in_first, in_last;
  logic [NP-1:0]    in_bp, out_valid, out_ready, out_first, out_last;
  logic [NP*DW-1:0] out_data;
  logic [NP*16-1:0] drop_cnt;

  switch_post_cell_buf #(.N_PORT(NP), .DATA_W(DW), .DEPTH(DEPTH), .BP_FREE(BPF)) dut (
    .clk(clk), .rstn(rstn), .in_wr(in_wr), .in_sel(in_sel), .in_din(in_din),
    .in_first(in_first), .in_last(in_last), .in_bp(in_bp), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_first(out_first),
    .out_last(out_last), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: per port a queue of committed words (each stamped with
  // the edge that committed its frame) and a queue of words of the open frame.
  typedef struct {
    logic [DW-1:0] d;
    logic          f;
    logic          l;
    int            stamp;
  } word_t;

  word_t cq   [NP][$];
  word_t pend [NP][$];
  bit    open_f [NP];
  bit    bad_f  [NP];
  int    drops  [NP];
  int    cyc;
  int    checks;
  int    errors;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Head word visible once its frame was committed at an earlier edge.
  function automatic bit exp_valid(int p);
    return (cq[p].size() > 0) && (cq[p][0].stamp < cyc);
  endfunction

  function automatic int exp_drop(int p);
`ifdef SWITCH_POST_DROP_CNT_EN
    return drops[p];
`else
    return 0 * p;
`endif
  endfunction

  task automatic model_clear();
    for (int p = 0; p < NP; p++) begin
      cq[p].delete();
      pend[p].delete();
      open_f[p] = 1'b0;
      bad_f[p]  = 1'b0;
      drops[p]  = 0;
    end
  endtask

  task automatic model_edge();
    bit    pop;
    word_t w;
    for (int p = 0; p < NP; p++) begin
      pop = exp_valid(p) && out_ready[p];
      if (in_wr && in_sel[p]) begin
        if (in_first) begin
          pend[p].delete();
          open_f[p] = 1'b1;
          bad_f[p]  = 1'b0;
        end
        if (open_f[p]) begin
          if (bad_f[p]) begin
            if (in_last) begin
              if (drops[p] < 65535) drops[p]++;
              pend[p].delete();
              open_f[p] = 1'b0;
            end
          end else if ((cq[p].size() + pend[p].size() < DEPTH) || pop) begin
            w.d = in_din; w.f = in_first; w.l = in_last; w.stamp = cyc + 1;
            pend[p].push_back(w);
            if (in_last) begin
              foreach (pend[p][k]) begin
                w = pend[p][k];
                w.stamp = cyc + 1;
                cq[p].push_back(w);
              end
              pend[p].delete();
              open_f[p] = 1'b0;
            end
          end else begin
            bad_f[p] = 1'b1;
            if (in_last) begin
              if (drops[p] < 65535) drops[p]++;
              pend[p].delete();
              open_f[p] = 1'b0;
            end
          end
        end
      end
      if (pop) void'(cq[p].pop_front());
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("valid[%0d]", p), DW'(out_valid[p]), DW'(exp_valid(p)));
      if (exp_valid(p)) begin
        chk($sformatf("data[%0d]", p), out_data[p*DW +: DW], cq[p][0].d);
        chk($sformatf("first[%0d]", p), DW'(out_first[p]), DW'(cq[p][0].f));
        chk($sformatf("last[%0d]", p), DW'(out_last[p]), DW'(cq[p][0].l));
      end
      chk($sformatf("bp[%0d]", p), DW'(in_bp[p]),
          DW'((DEPTH - cq[p].size() - pend[p].size()) < BPF));
      chk($sformatf("drop[%0d]", p), DW'(drop_cnt[p*16 +: 16]), DW'(exp_drop(p)));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic drive(input logic [NP-1:0] sel, input logic f, input logic l, input bit rnd);
    in_wr    = 1'b1;
    in_sel   = sel;
    in_first = f;
    in_last  = l;
    in_din   = {$urandom, $urandom, $urandom, $urandom};
    if (rnd) out_ready = NP'($urandom);
    step();
    in_wr    = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [NP-1:0] sel, input int n);
    for (int w = 0; w < n; w++) drive(sel, w == 0, w == n - 1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    model_clear();
    rstn = 1'b0; in_wr = 1'b0; in_sel = '0; in_din = '0;
    in_first = 1'b0; in_last = 1'b0; out_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", DW'(out_valid), '0);
    chk("rst_bp", DW'(in_bp), '0);
    chk("rst_data", out_data[DW-1:0], '0);
    chk("rst_data3", out_data[3*DW +: DW], '0);
    chk("rst_first", DW'(out_first), '0);
    chk("rst_last", DW'(out_last), '0);
    chk("rst_drop", DW'(drop_cnt), '0);
    rstn = 1'b1;

    // Single 4-word frame to port 0, latency one edge after last.
    out_ready = '1;
    send_frame(4'b0001, 4);
    chk("t1_lat_k", DW'(out_valid[0]), '0);
    step();
    chk("t1_lat_k1", DW'(out_valid), DW'(4'b0001));
    idle(8);

    // Multicast to ports 1 and 3.
    send_frame(4'b1010, 3);
    step();
    chk("t2_mcast", DW'(out_valid), DW'(4'b1010));
    idle(6);

    // Oversized frame to port 2 is dropped, next frame passes.
    out_ready = 4'b1011;
    send_frame(4'b0100, 70);
    idle(2);
    chk("t3_noout", DW'(out_valid[2]), '0);
`ifdef SWITCH_POST_DROP_CNT_EN
    chk("t3_drop", DW'(drop_cnt[2*16 +: 16]), DW'(1));
`else
    chk("t3_drop", DW'(drop_cnt[2*16 +: 16]), DW'(0));
`endif
    out_ready = '1;
    send_frame(4'b0100, 4);
    idle(8);

    // Unterminated frame is silently replaced by the next one.
    drive(4'b0001, 1'b1, 1'b0, 1'b0);
    drive(4'b0001, 1'b0, 1'b0, 1'b0);
    drive(4'b0001, 1'b0, 1'b0, 1'b0);
    send_frame(4'b0001, 3);
    idle(6);
    chk("t4_drop", DW'(drop_cnt[15:0]), DW'(0));

    // Backpressure threshold on port 1.
    out_ready = 4'b1101;
    send_frame(4'b0010, 49);
    chk("t5_bp_set", DW'(in_bp[1]), DW'(1));
    out_ready = '1;
    idle(3);
    chk("t5_bp_clr", DW'(in_bp[1]), DW'(0));
    idle(55);

    // Full queue accepts a write on an edge that also reads.
    out_ready = 4'b0111;
    send_frame(4'b1000, 64);
    idle(2);
    out_ready = '1;
    send_frame(4'b1000, 2);
    idle(70);

    // Randomized multicast traffic with random ready and truncated frames.
    for (int fr = 0; fr < 60; fr++) begin
      automatic logic [NP-1:0] sel = NP'($urandom_range(1, 15));
      automatic int  len  = $urandom_range(1, 8);
      automatic bit  trunc = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) drive(sel, 1'b0, 1'b0, 1'b1);
      for (int w = 0; w < len; w++)
        drive(sel, w == 0, (w == len - 1) && !trunc, 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        out_ready = NP'($urandom);
        step();
      end
    end
    out_ready = '1;
    idle(80);
    chk("rand_drained", DW'(out_valid), '0);

    // Asynchronous reset with queued and partial frames.
    out_ready = '0;
    send_frame(4'b0001, 50);
    drive(4'b0001, 1'b1, 1'b0, 1'b0);
    drive(4'b0001, 1'b0, 1'b0, 1'b0);
    step();
    chk("t6_bp_pre", DW'(in_bp[0]), DW'(1));
    chk("t6_vld_pre", DW'(out_valid[0]), DW'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_vld_async", DW'(out_valid), '0);
    chk("t6_bp_async", DW'(in_bp), '0);
    model_clear();
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_all();
    rstn = 1'b1;
    out_ready = '1;
    send_frame(4'b0001, 3);
    step();
    chk("t6_after", DW'(out_valid), DW'(4'b0001));
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
